xadc_multi_sampler: RTL and testbench



---
 rtl/xadc_multi_sampler.sv | 148 ++++++++++++++
 tb/tb_xadc_multi_sampler.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xadc_multi_sampler.sv
`default_nettype none
// ============================================================================
// xadc_multi_sampler : reads each converted XADC channel over DRP on eoc and
//                      keeps a per-channel exponential average on a flat bus.
// Revision 1.0 - initial release
// ============================================================================
module xadc_multi_sampler #(
   parameter int                  NUM_CH    = 4,
   parameter logic [NUM_CH*7-1:0] CH_ADDR   = {7'h13, 7'h12, 7'h11, 7'h03},
   parameter int                  AVG_SHIFT = 2,
   parameter int                  OUT_W     = 12,
   parameter int                  TIMEOUT   = 63,
   localparam int                 IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    eoc,
   input  logic [4:0]              channel_in,
   input  logic [15:0]             drp_do,
   input  logic                    drp_drdy,
   output logic                    drp_den,
   output logic [6:0]              drp_daddr,
   output logic [NUM_CH*OUT_W-1:0] data_out,
   output logic                    data_valid,
   output logic [IDX_W-1:0]        data_ch,
   input  logic                    clr_flags,
   output logic                    overrun,
   output logic                    timeout_err
);

   localparam int              ACC_W       = OUT_W + AVG_SHIFT;
   localparam int              CNT_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, UPDATE} state_t;

   state_t              state;
   logic [IDX_W-1:0]    idx;
   logic                pend;
   logic [IDX_W-1:0]    pend_idx;
   logic [CNT_W-1:0]    wait_cnt;
   logic [ACC_W-1:0]    acc [NUM_CH];
   logic [NUM_CH-1:0]   seeded;

   logic                hit;
   logic [IDX_W-1:0]    hit_idx;
   logic                launch;
   logic [IDX_W-1:0]    launch_idx;
   logic                consume;
   logic                queue;
   logic [OUT_W-1:0]    sample;
   logic [ACC_W-1:0]    cur_acc;
   logic [ACC_W-1:0]    new_acc;
   logic                unused_do;

   // Descending scan so the lowest matching index is the one that sticks.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (CH_ADDR[7*i +: 7] == {2'b00, channel_in}) begin
            hit     = eoc;
            hit_idx = IDX_W'(i);
         end
      end
   end

   // A waiting request is always served before a fresh eoc; the fresh one queues.
   assign launch     = ((state == IDLE) && (pend || hit)) || ((state == UPDATE) && pend);
   assign launch_idx = pend ? pend_idx : hit_idx;
   assign consume    = launch && pend;
   assign queue      = hit && ((state != IDLE) || pend);

   assign sample    = drp_do[15 -: OUT_W];
   assign cur_acc   = acc[idx];
   assign new_acc   = seeded[idx] ? (cur_acc - (cur_acc >> AVG_SHIFT) + ACC_W'(sample))
                                  : (ACC_W'(sample) << AVG_SHIFT);
   assign unused_do = ^drp_do;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= '0;
         pend        <= 1'b0;
         pend_idx    <= '0;
         wait_cnt    <= '0;
         seeded      <= '0;
         for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
         drp_den     <= 1'b0;
         drp_daddr   <= '0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         data_ch     <= '0;
         overrun     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         drp_den    <= 1'b0;
         data_valid <= 1'b0;
         if (clr_flags) begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
         end

         if (queue) begin
            pend     <= 1'b1;
            pend_idx <= hit_idx;
            if (pend && !consume) overrun <= 1'b1;
         end else if (consume) begin
            pend <= 1'b0;
         end

         if (launch) begin
            state     <= REQ;
            idx       <= launch_idx;
            drp_den   <= 1'b1;
            drp_daddr <= CH_ADDR[7*launch_idx +: 7];
         end else begin
            case (state)
               IDLE: begin
               end
               REQ: begin
                  state    <= WAIT;
                  wait_cnt <= '0;
               end
               WAIT: begin
                  if (drp_drdy) begin
                     acc[idx]                     <= new_acc;
                     seeded[idx]                  <= 1'b1;
                     data_out[OUT_W*idx +: OUT_W] <= OUT_W'(new_acc >> AVG_SHIFT);
                     data_valid                   <= 1'b1;
                     data_ch                      <= idx;
                     state                        <= UPDATE;
                  end else if (wait_cnt == TIMEOUT_CNT) begin
                     timeout_err <= 1'b1;
                     state       <= IDLE;
                  end else begin
                     wait_cnt <= wait_cnt + 1'b1;
                  end
               end
               UPDATE: state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_xadc_multi_sampler.sv
`default_nettype none
// ============================================================================
// tb_xadc_multi_sampler : scoreboard bench for xadc_multi_sampler
// Revision 1.0 - initial release
// ============================================================================
module tb_xadc_multi_sampler;

   logic        clk = 1'b0;
   logic        rst;
   logic        eoc;
   logic [4:0]  channel_in;
   logic [15:0] drp_do;
   logic        drp_drdy;
   logic        den;
   logic [6:0]  daddr;
   logic [47:0] data_out;
   logic        data_valid;
   logic [1:0]  data_ch;
   logic        clr_flags;
   logic        overrun;
   logic        timeout_err;

   int n_chk  = 0;
   int n_fail = 0;
   int valid_cnt = 0;

   typedef struct {
      int          ch;
      logic [47:0] bus;
   } exp_t;

   exp_t        sb [$];
   exp_t        mon_e;
   logic [13:0] m_acc [4];
   logic [3:0]  m_seed;
   logic [47:0] m_bus;

   xadc_multi_sampler #(
      .NUM_CH    (4),
      .CH_ADDR   ({7'h13, 7'h12, 7'h11, 7'h03}),
      .AVG_SHIFT (2),
      .OUT_W     (12),
      .TIMEOUT   (63)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .eoc         (eoc),
      .channel_in  (channel_in),
      .drp_do      (drp_do),
      .drp_drdy    (drp_drdy),
      .drp_den     (den),
      .drp_daddr   (daddr),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .data_ch     (data_ch),
      .clr_flags   (clr_flags),
      .overrun     (overrun),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_acc[i] = '0;
      m_seed = '0;
      m_bus  = '0;
   endtask

   task automatic model_push(input int ch, input logic [11:0] s);
      if (m_seed[ch]) m_acc[ch] = m_acc[ch] - (m_acc[ch] >> 2) + 14'(s);
      else            m_acc[ch] = {s, 2'b00};
      m_seed[ch] = 1'b1;
      m_bus[ch*12 +: 12] = m_acc[ch][13:2];
      sb.push_back('{ch: ch, bus: m_bus});
   endtask

   task automatic pulse_eoc(input logic [4:0] ch);
      eoc        = 1'b1;
      channel_in = ch;
      tick();
      eoc        = 1'b0;
      channel_in = 5'h00;
   endtask

   task automatic expect_den(input logic [6:0] addr);
      int n = 0;
      while (den !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      chk("den_seen", den, 1);
      chk("daddr", daddr, addr);
   endtask

   task automatic give_drdy(input int ch, input logic [11:0] s);
      drp_do   = {s, 4'h0};
      drp_drdy = 1'b1;
      model_push(ch, s);
      tick();
      drp_drdy = 1'b0;
      drp_do   = 16'h0000;
   endtask

   task automatic expect_quiet(input string tag, input int n);
      logic seen = 1'b0;
      repeat (n) begin
         seen = seen | den | data_valid;
         tick();
      end
      chk(tag, seen, 0);
   endtask

   task automatic read_ch(input logic [4:0] ch, input logic [6:0] addr, input int idx,
                          input logic [11:0] s);
      pulse_eoc(ch);
      expect_den(addr);
      repeat (2) tick();
      give_drdy(idx, s);
      tick();
   endtask

   always @(negedge clk) begin
      if (!rst && data_valid) begin
         valid_cnt++;
         if (sb.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            chk("data_ch", 64'(data_ch), 64'(mon_e.ch));
            chk("data_out", data_out, mon_e.bus);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int vbefore;
      rst = 1'b1; eoc = 1'b0; channel_in = '0; drp_do = '0; drp_drdy = 1'b0; clr_flags = 1'b0;
      model_reset();
      repeat (3) tick();
      chk("rst_data_out", data_out, 0);
      chk("rst_valid", data_valid, 0);
      chk("rst_den", den, 0);
      chk("rst_daddr", daddr, 0);
      chk("rst_flags", {overrun, timeout_err}, 0);
      rst = 1'b0;
      tick();

      // single channel, first sample passes straight through
      pulse_eoc(5'h03);
      chk("den_latency", den, 1);
      chk("daddr_ch0", daddr, 7'h03);
      tick();
      chk("den_one_cycle", den, 0);
      repeat (3) tick();
      give_drdy(0, 12'hABC);
      tick();

      // averaging on channel 0x11 (slice 1)
      read_ch(5'h11, 7'h11, 1, 12'h800);
      read_ch(5'h11, 7'h11, 1, 12'hC00);
      chk("avg_slice1", data_out[23:12], 12'h900);

      // unmatched channel
      pulse_eoc(5'h07);
      expect_quiet("unmatched_quiet", 5);
      chk("unmatched_flags", {overrun, timeout_err}, 0);

      // pending / overrun, with a set coinciding with clr
      pulse_eoc(5'h03);
      expect_den(7'h03);
      tick();
      pulse_eoc(5'h11);
      chk("first_pend_no_ovr", overrun, 0);
      pulse_eoc(5'h12);
      chk("ovr_set", overrun, 1);
      clr_flags = 1'b1;
      pulse_eoc(5'h13);
      clr_flags = 1'b0;
      chk("set_beats_clr", overrun, 1);
      give_drdy(0, 12'h100);
      expect_den(7'h13);
      tick();
      give_drdy(3, 12'h555);
      tick();
      expect_quiet("no_extra_read", 5);
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      chk("ovr_cleared", overrun, 0);

      // timeout with no drdy
      pulse_eoc(5'h12);
      chk("den_to", den, 1);
      vbefore = valid_cnt;
      repeat (64) tick();
      chk("to_not_early", timeout_err, 0);
      tick();
      chk("to_set", timeout_err, 1);
      chk("to_no_valid", valid_cnt, vbefore);
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      chk("to_cleared", timeout_err, 0);

      // drdy exactly on the last wait cycle is a success
      pulse_eoc(5'h12);
      chk("den_after_to", den, 1);
      repeat (64) tick();
      give_drdy(2, 12'h7FF);
      chk("to_boundary_ok", timeout_err, 0);
      tick();

      // reset in WAIT, late drdy ignored, then clean restart
      pulse_eoc(5'h11);
      expect_den(7'h11);
      repeat (2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      chk("midrst_data_out", data_out, 0);
      chk("midrst_valid_den", {data_valid, den}, 0);
      chk("midrst_ch_addr", {data_ch, daddr}, 0);
      drp_do   = 16'hFFF0;
      drp_drdy = 1'b1;
      tick();
      drp_drdy = 1'b0;
      drp_do   = 16'h0000;
      expect_quiet("late_drdy_quiet", 4);
      read_ch(5'h11, 7'h11, 1, 12'h400);
      chk("restart_unseeded", data_out, {24'h0, 12'h400, 12'h0});

      repeat (3) tick();
      chk("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
